// File: rtl/scan_frame_ctrl.sv
// Serial scan front-end for the AES core: deserialises {key, data, tag}, pulses Krdy/Drdy,
// waits for the core result (with timeout) and serialises {result, status, tag} back out.
module scan_frame_ctrl #(
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned OUT_W   = 128,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              scan_en,
  input  logic              scan_in,
  output logic              scan_out,
  output logic              scan_out_vld,
  input  logic              scan_out_rdy,
  output logic [KEY_W-1:0]  Kin,
  output logic [DATA_W-1:0] Din,
  output logic              Krdy,
  output logic              Drdy,
  input  logic [OUT_W-1:0]  core_dout,
  input  logic              core_dvld,
  output logic              busy
);

  localparam int unsigned IN_LEN  = KEY_W + DATA_W + TAG_W;
  localparam int unsigned OUT_LEN = OUT_W + 2 + TAG_W;
  localparam int unsigned IN_CW   = $clog2(IN_LEN);
  localparam int unsigned OUT_CW  = $clog2(OUT_LEN);
  localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_SHIFT_IN,
    S_UPDATE,
    S_LOAD_K,
    S_LOAD_D,
    S_WAIT,
    S_SHIFT_OUT
  } state_e;

  state_e              state_q, state_d;
  logic [IN_LEN-1:0]   in_sr_q, in_sr_d;
  logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_LEN-1:0]  out_sr_q, out_sr_d;
  logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
  logic [KEY_W-1:0]    kin_q, kin_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [1:0]          status_q, status_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                ovr;
  logic                ovr_sticky;

  always_comb begin
    state_d    = state_q;
    in_sr_d    = in_sr_q;
    in_cnt_d   = in_cnt_q;
    out_sr_d   = out_sr_q;
    out_cnt_d  = out_cnt_q;
    kin_d      = kin_q;
    din_d      = din_q;
    tag_d      = tag_q;
    status_d   = status_q;
    timer_d    = timer_q;

    ovr        = scan_en && (state_q != S_SHIFT_IN);
    ovr_sticky = status_q[1] | ovr;
    if (ovr) status_d[1] = 1'b1;

    case (state_q)
      S_SHIFT_IN: begin
        if (scan_en) begin
          in_sr_d = {scan_in, in_sr_q[IN_LEN-1:1]};
          if (in_cnt_q == IN_CW'(IN_LEN - 1)) begin
            in_cnt_d = '0;
            state_d  = S_UPDATE;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_UPDATE: begin
        din_d = in_sr_q[TAG_W +: DATA_W];
        tag_d = in_sr_q[TAG_W-1:0];
        // Key reuse keeps the previously loaded key on Kin, matching what the core holds.
        if (in_sr_q[0]) begin
          state_d = S_LOAD_D;
        end else begin
          kin_d   = in_sr_q[TAG_W+DATA_W +: KEY_W];
          state_d = S_LOAD_K;
        end
      end
      S_LOAD_K: state_d = S_LOAD_D;
      S_LOAD_D: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_dvld) begin
          out_sr_d    = {core_dout, ovr_sticky, 1'b0, tag_q};
          status_d[0] = 1'b0;
          state_d     = S_SHIFT_OUT;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          out_sr_d    = {{OUT_W{1'b0}}, ovr_sticky, 1'b1, tag_q};
          status_d[0] = 1'b1;
          state_d     = S_SHIFT_OUT;
        end
      end
      S_SHIFT_OUT: begin
        if (scan_out_rdy) begin
          out_sr_d = {1'b0, out_sr_q[OUT_LEN-1:1]};
          if (out_cnt_q == OUT_CW'(OUT_LEN - 1)) begin
            out_cnt_d = '0;
            // An overrun on the closing cycle still belongs to the next frame.
            status_d  = {ovr, 1'b0};
            state_d   = S_SHIFT_IN;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_SHIFT_IN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_SHIFT_IN;
      in_sr_q   <= '0;
      in_cnt_q  <= '0;
      out_sr_q  <= '0;
      out_cnt_q <= '0;
      kin_q     <= '0;
      din_q     <= '0;
      tag_q     <= '0;
      status_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_sr_q   <= in_sr_d;
      in_cnt_q  <= in_cnt_d;
      out_sr_q  <= out_sr_d;
      out_cnt_q <= out_cnt_d;
      kin_q     <= kin_d;
      din_q     <= din_d;
      tag_q     <= tag_d;
      status_q  <= status_d;
      timer_q   <= timer_d;
    end
  end

  assign Kin          = kin_q;
  assign Din          = din_q;
  assign Krdy         = (state_q == S_LOAD_K);
  assign Drdy         = (state_q == S_LOAD_D);
  assign scan_out_vld = (state_q == S_SHIFT_OUT);
  assign scan_out     = out_sr_q[0];
  assign busy         = (state_q != S_SHIFT_IN);

endmodule

// File: tb/tb_scan_frame_ctrl.sv
// Bench for scan_frame_ctrl: vector table of frames plus reset/overrun/flow-control sequences,
// with expected output frames queued at stimulus time and popped when the DUT shifts them out.
module tb_scan_frame_ctrl;

  localparam int unsigned KEY_W   = 128;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned OUT_W   = 128;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned IN_LEN  = KEY_W + DATA_W + TAG_W;
  localparam int unsigned OUT_LEN = OUT_W + 2 + TAG_W;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1 = 128'hB9D1C48E348FE771FA464A77A178FB07;
  localparam logic [127:0] R1 = 128'h95F8847369A8573D76AF987AB30A5DE2;
  localparam logic [127:0] D2 = 128'hDCFEAD50D1D9FD08B386EFB08B142F74;
  localparam logic [127:0] R2 = 128'h85E5F163C857B0AC1162E07DD3432B66;

  logic              CLK, RST;
  logic              scan_en, scan_in, scan_out, scan_out_vld, scan_out_rdy;
  logic [KEY_W-1:0]  Kin;
  logic [DATA_W-1:0] Din;
  logic              Krdy, Drdy, core_dvld, busy;
  logic [OUT_W-1:0]  core_dout;

  scan_frame_ctrl #(
    .KEY_W(KEY_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .scan_en(scan_en), .scan_in(scan_in),
    .scan_out(scan_out), .scan_out_vld(scan_out_vld), .scan_out_rdy(scan_out_rdy),
    .Kin(Kin), .Din(Din), .Krdy(Krdy), .Drdy(Drdy),
    .core_dout(core_dout), .core_dvld(core_dvld), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] res;
    logic [3:0]   tag;
    int           dly;        // dvld this many cycles after Drdy; 0 = never
    bit           toggle;     // scan_out_rdy alternates 1/0
    bit           ovr;        // pulse scan_en during WAIT
    logic [1:0]   exp_status; // {overrun, timeout}
  } vec_t;

  vec_t               vecs[8];
  logic [OUT_LEN-1:0] sb_q[$];
  int                 errors = 0;
  int                 checks = 0;

  function automatic vec_t mkvec(input logic [127:0] key, din, res, input logic [3:0] tag,
                                 input int dly, input bit toggle, ovr, input logic [1:0] st);
    vec_t v;
    v.key = key; v.din = din; v.res = res; v.tag = tag; v.dly = dly;
    v.toggle = toggle; v.ovr = ovr; v.exp_status = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tagname);
    chk({tagname, "_kin"}, Kin, '0);
    chk({tagname, "_din"}, Din, '0);
    chk({tagname, "_ctl"}, {Krdy, Drdy, scan_out, scan_out_vld, busy}, '0);
  endtask

  // Entered and left on a negedge; the first input bit is driven immediately.
  task automatic run_frame(input vec_t v);
    logic [IN_LEN-1:0]  fr;
    logic [OUT_LEN-1:0] got, exp_fr;
    int kcnt, kpos, dpos, lat, idx, exp_lat;
    bit vld_lost, exp_k;
    fr  = {v.key, v.din, v.tag};
    got = '0;
    sb_q.push_back({(v.exp_status[0] ? 128'd0 : v.res), v.exp_status, v.tag});
    for (int i = 0; i < int'(IN_LEN); i++) begin
      if (i > 0) @(negedge CLK);
      scan_en = 1'b1;
      scan_in = fr[i];
    end
    @(negedge CLK);
    scan_en = 1'b0; scan_in = 1'b0; scan_out_rdy = 1'b1;

    kcnt = 0; kpos = -1; dpos = -1;
    for (int k = 0; k < 8 && dpos < 0; k++) begin
      if (Krdy) begin kcnt++; kpos = k; end
      if (Drdy) dpos = k;
      else @(negedge CLK);
    end
    exp_k = ~v.tag[0];
    chk("drdy_seen", dpos >= 0, 1);
    chk("krdy_count", kcnt, exp_k);
    chk("krdy_before_drdy", kpos, exp_k ? dpos - 1 : -1);
    chk("kin_at_drdy", Kin, v.key);
    chk("din_at_drdy", Din, v.din);
    if (dpos < 0) begin void'(sb_q.pop_front()); return; end

    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge CLK);
      if (scan_out_vld) begin lat = c; break; end
      core_dvld = (v.dly != 0) && (c == v.dly);
      core_dout = core_dvld ? v.res : ~v.res;
      scan_en   = v.ovr && (c == 3);
      scan_in   = 1'b1;
    end
    core_dvld = 1'b0; core_dout = '0; scan_en = 1'b0; scan_in = 1'b0;
    exp_lat = (v.dly == 0) ? int'(TIMEOUT) + 1 : v.dly + 1;
    chk("wait_latency", lat, exp_lat);
    if (lat < 0) begin void'(sb_q.pop_front()); return; end

    idx = 0; vld_lost = 1'b0;
    for (int cyc = 0; cyc < 4 * int'(OUT_LEN) && idx < int'(OUT_LEN); cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (!scan_out_vld) vld_lost = 1'b1;
      scan_out_rdy = !v.toggle || (cyc % 2 == 0);
      if (scan_out_rdy) begin got[idx] = scan_out; idx++; end
    end
    @(negedge CLK);
    scan_out_rdy = 1'b0;
    chk("vld_held", vld_lost, 0);
    chk("out_bit_count", idx, OUT_LEN);
    chk("idle_after_frame", {scan_out_vld, busy}, 0);
    exp_fr = sb_q.pop_front();
    chk("out_frame", got, exp_fr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = mkvec(K1, D1, R1, 4'h0,  12, 1'b0, 1'b0, 2'b00); // T1
    vecs[1] = mkvec(K1, D2, R2, 4'h1,  12, 1'b0, 1'b0, 2'b00); // T2 key reuse
    vecs[2] = mkvec(K1, D1, R1, 4'hA,   0, 1'b0, 1'b0, 2'b01); // T3 timeout
    vecs[3] = mkvec(K1, D2, R2, 4'h6,  20, 1'b0, 1'b1, 2'b10); // T4 overrun
    vecs[4] = mkvec(K1, D1, R1, 4'h0,  12, 1'b0, 1'b0, 2'b00); // T4 follow-up, cleared
    vecs[5] = mkvec(K1, D1, R1, 4'h0,  12, 1'b1, 1'b0, 2'b00); // T5 rdy toggling
    vecs[6] = mkvec(K1, D2, R2, 4'h3, 255, 1'b0, 1'b0, 2'b00); // dvld on timeout cycle wins
    vecs[7] = mkvec(K1, D1, R1, 4'h0,   1, 1'b0, 1'b0, 2'b00); // dvld on first WAIT cycle

    RST = 1'b1; scan_en = 1'b0; scan_in = 1'b0; scan_out_rdy = 1'b0;
    core_dvld = 1'b0; core_dout = '0;
    repeat (3) @(negedge CLK);
    check_reset_outs("reset");
    RST = 1'b0;
    @(negedge CLK);

    for (int n = 0; n < 8; n++) run_frame(vecs[n]);

    // T6: abort a partial frame with reset, then a clean T1 frame.
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge CLK);
      scan_en = 1'b1;
      scan_in = i[0];
    end
    @(negedge CLK);
    scan_en = 1'b0; scan_in = 1'b0;
    RST = 1'b1;
    #1;
    check_reset_outs("midframe_reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_frame(vecs[0]);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
